// File: rtl/mappy_sprite_scan_if.sv
// Sprite scanner bus: object-RAM read port, line control, status and
// read-list access, bundled for the scanner and its host.
//   master : host side (line timing, object RAM data, read index)
//   slave  : scanner side (RAM address, status, registered read data)
interface mappy_sprite_scan_if #(
  parameter int MAX_SPR = 16
);
  localparam int IW = $clog2(MAX_SPR);
  localparam int CW = IW + 1;

  logic          line_start;
  logic [7:0]    next_vline;
  logic [10:0]   AB_obj;
  logic [7:0]    obj1in;
  logic [7:0]    obj2in;
  logic [7:0]    obj3in;
  logic          scan_busy;
  logic          scan_done;
  logic [CW-1:0] spr_count;
  logic          overflow;
  logic [IW-1:0] rd_idx;
  logic [31:0]   rd_data;

  modport master (
    output line_start, next_vline, obj1in, obj2in, obj3in, rd_idx,
    input  AB_obj, scan_busy, scan_done, spr_count, overflow, rd_data
  );

  modport slave (
    input  line_start, next_vline, obj1in, obj2in, obj3in, rd_idx,
    output AB_obj, scan_busy, scan_done, spr_count, overflow, rd_data
  );
endinterface

// File: rtl/mappy_sprite_scan.sv
// Per-line sprite evaluator. Walks the sprite attribute area of object RAM
// (0x780..0x7FF), keeps sprites that intersect the line being prepared and
// stores up to MAX_SPR decoded descriptors in a ping-pong list. Lists swap
// on every line_start so the renderer reads a stable list.
//   clk_18432 : system clock (rising edge)
//   reset     : synchronous, active high
//   bus       : scanner side of mappy_sprite_scan_if (RAM port, line
//               control, status, read list)
module mappy_sprite_scan #(
  parameter int MAX_SPR = 16,
  parameter int NUM_SPR = 64
) (
  input  logic                 clk_18432,
  input  logic                 reset,
  mappy_sprite_scan_if.slave   bus
);
  localparam int IW = $clog2(MAX_SPR);
  localparam int CW = IW + 1;
  localparam int NW = $clog2(NUM_SPR);

  typedef enum logic [2:0] {IDLE, RD0, RD1, EVAL, DONE} state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [CW-1:0] wcount_q, wcount_d;
  logic [7:0]    vline_q, vline_d;
  logic [7:0]    tile_q, tile_d;
  logic [7:0]    ypos_q, ypos_d;
  logic          flipx_q, flipx_d;
  logic          flipy_q, flipy_d;
  logic [1:0]    xsize_q, xsize_d;
  logic          wsel_q, wsel_d;     // list currently being written
  logic [CW-1:0] rcount_q, rcount_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic [31:0]   list_mem [2][MAX_SPR];

  logic [8:0]    y_v_add;
  logic          spr_dis;
  logic          match;
  logic [31:0]   desc;
  logic          wr_en;
  logic          scanning;
  logic          unused_bits;

  assign unused_bits = &{1'b0, bus.obj3in[7:4]};

  // Byte 1 is evaluated straight off the RAM outputs during EVAL.
  always_comb begin
    y_v_add = {1'b0, ypos_q} + {1'b0, vline_q}
            + (xsize_q[1] ? 9'd16 : 9'd0) - 9'd1;
    spr_dis = bus.obj3in[1];
    match   = !spr_dis && (xsize_q[1] ? (y_v_add[8:5] == 4'b0111)
                                      : (y_v_add[8:4] == 5'b01110));
    desc    = {tile_q, bus.obj1in[5:0], bus.obj3in[0], bus.obj2in,
               y_v_add[4:0], flipx_q, flipy_q, xsize_q};
  end

  // State and datapath registers
  always_ff @(posedge clk_18432) begin
    if (reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      wcount_q  <= '0;
      vline_q   <= '0;
      tile_q    <= '0;
      ypos_q    <= '0;
      flipx_q   <= 1'b0;
      flipy_q   <= 1'b0;
      xsize_q   <= '0;
      wsel_q    <= 1'b0;
      rcount_q  <= '0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      wcount_q  <= wcount_d;
      vline_q   <= vline_d;
      tile_q    <= tile_d;
      ypos_q    <= ypos_d;
      flipx_q   <= flipx_d;
      flipy_q   <= flipy_d;
      xsize_q   <= xsize_d;
      wsel_q    <= wsel_d;
      rcount_q  <= rcount_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  // List storage has no reset; the counts alone decide what is visible.
  always_ff @(posedge clk_18432) begin
    if (wr_en) list_mem[wsel_q][wcount_q[IW-1:0]] <= desc;
  end

  // Next state and datapath
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    wcount_d  = wcount_q;
    vline_d   = vline_q;
    tile_d    = tile_q;
    ypos_d    = ypos_q;
    flipx_d   = flipx_q;
    flipy_d   = flipy_q;
    xsize_d   = xsize_q;
    wsel_d    = wsel_q;
    rcount_d  = rcount_q;
    ovf_d     = ovf_q;
    rd_data_d = (CW'(bus.rd_idx) < rcount_q) ? list_mem[~wsel_q][bus.rd_idx]
                                             : 32'd0;

    case (state_q)
      IDLE: ;
      RD0:  state_d = RD1;
      RD1: begin
        state_d = EVAL;
        tile_d  = bus.obj1in;
        ypos_d  = bus.obj2in;
        flipx_d = bus.obj3in[0];
        flipy_d = bus.obj3in[1];
        xsize_d = bus.obj3in[3:2];
      end
      EVAL: begin
        n_d = n_q + 1'b1;
        if (wr_en) wcount_d = wcount_q + 1'b1;
        // Stop early once the entry just written fills the list.
        if (n_q == NW'(NUM_SPR - 1) || (match && wcount_q == CW'(MAX_SPR - 1)))
          state_d = DONE;
        else
          state_d = RD0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Line boundary: publish the write list (even a partial one) and
    // restart into the other list. Overrides anything above.
    if (bus.line_start) begin
      state_d  = RD0;
      n_d      = '0;
      wcount_d = '0;
      vline_d  = bus.next_vline;
      wsel_d   = ~wsel_q;
      rcount_d = wcount_q;
      ovf_d    = (wcount_q == CW'(MAX_SPR)) || scanning;
    end
  end

  // Outputs
  always_comb begin
    bus.AB_obj    = 11'h780;
    bus.scan_busy = 1'b0;
    bus.scan_done = 1'b0;
    scanning      = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      RD0: begin
        bus.AB_obj    = 11'h780 + 11'({n_q, 1'b0});
        bus.scan_busy = 1'b1;
        scanning      = 1'b1;
      end
      RD1: begin
        bus.AB_obj    = 11'h781 + 11'({n_q, 1'b0});
        bus.scan_busy = 1'b1;
        scanning      = 1'b1;
      end
      EVAL: begin
        bus.scan_busy = 1'b1;
        scanning      = 1'b1;
        // A coinciding line_start publishes the list as it stood.
        wr_en         = match && !bus.line_start;
      end
      DONE:    bus.scan_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.spr_count = rcount_q;
  assign bus.overflow  = ovf_q;
  assign bus.rd_data   = rd_data_q;
endmodule

// File: doc/mappy_sprite_scan.md
# mappy_sprite_scan

Per-line sprite evaluator feeding the sprite line renderer. During each scanline it walks the 64-entry sprite attribute area of object RAM, selects the sprites that intersect the next line to be drawn, and stores up to `MAX_SPR` pre-decoded descriptors in a ping-pong list. At every line boundary the lists swap, so the renderer reads a stable list for line N while line N+1 is being scanned.

## Interface
Parameters:
- `MAX_SPR`, 16: list depth (entries per line); `rd_idx` width is log2(`MAX_SPR`).
- `NUM_SPR`, 64: sprite entries scanned, two object-RAM bytes each.

Ports:
- `clk_18432`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `line_start`  in  1  one-clock pulse at the start of each line; swaps lists and starts a scan.
- `next_vline`  in  8  line being prepared; sampled on `line_start`.
- `AB_obj`  out  11  object RAM address, shared by all three banks.
- `obj1in`, `obj2in`, `obj3in`  in  8 each  bank data; synchronous RAM with 1-clock read latency.
- `scan_busy`  out  1  scan in progress.
- `scan_done`  out  1  one-clock pulse when a scan finishes.
- `spr_count`  out  5  valid entries in the read list.
- `overflow`  out  1  read list truncated (full, or scan aborted).
- `rd_idx`  in  4  read-list index.
- `rd_data`  out  32  descriptor {tileno[7:0], palno[5:0], xpos[8:0], yrow[4:0], flipx, flipy, xsize[1:0]}.

## Operation
- Sprite n (0..63) occupies byte 0 at `AB_obj` = 0x780+2n and byte 1 at 0x781+2n.
- Byte 0 fields: tileno = `obj1in`; ypos = `obj2in`; flipx = `obj3in`[0]; flipy = `obj3in`[1]; xsize = `obj3in`[3:2].
- Byte 1 fields: palno = `obj1in`[5:0]; xpos = {`obj3in`[0], `obj2in`}; disable = `obj3in`[1].
- FSM states: IDLE, RD0, RD1, EVAL, DONE.
  - IDLE -> RD0 on `line_start`. Latch `next_vline`; set n=0 and wcount=0.
  - RD0: drive the byte-0 address.
  - RD1: drive the byte-1 address; capture byte 0.
  - EVAL: capture byte 1, evaluate, and write the entry if it matches. Then go to RD0 with n+1, or to DONE after n=63 or when the list becomes full.
  - DONE: pulse `scan_done` for one clock, then go to IDLE.
- Match arithmetic (9-bit, wraps mod 512): y_v_add = ypos + vline + (xsize[1] ? 16 : 0) − 1.
  - xsize[1]=1: match when y_v_add[8:5] = 4'b0111.
  - xsize[1]=0: match when y_v_add[8:4] = 5'b01110.
  - A sprite with disable=1 never matches.
- The stored yrow is raw y_v_add[4:0]. Flip is applied by the renderer.
- A matching sprite is written to the write list at index wcount, then wcount increments.
- If wcount reaches `MAX_SPR`, the scan stops, the list is marked full (overflow=1), and the FSM goes to DONE. Later sprites are ignored.
- Swap on `line_start`, all in the same edge:
  - write list becomes the read list;
  - `spr_count` ← wcount;
  - `overflow` ← full flag, OR 1 if the FSM was not in IDLE/DONE (aborted scan; its partial list is still published);
  - the scan restarts into the other list.
- While no scan is running, `AB_obj` holds 0x780.

## Timing
- Each sprite takes 3 clocks; a full scan is 192 clocks plus 1 DONE clock.
- `scan_busy` rises on the clock after `line_start` and falls when entering DONE.
- `rd_data` is registered: it is valid one clock after `rd_idx` changes. It reads 0 when `rd_idx` ≥ `spr_count`.
- Read-list contents, `spr_count` and `overflow` change only on the `line_start` edge or on `reset`.
- A `line_start` that coincides with DONE counts as a normal completion, not an abort.
- Reset values:
  - FSM in IDLE;
  - `AB_obj` = 0x780;
  - `scan_busy`, `scan_done`, `overflow` = 0;
  - `spr_count` = 0;
  - `rd_data` = 0;
  - both list counts cleared.
- Reset during a scan discards the scan. No swap happens.

## Test plan
- Single match: vline=0x10; sprite 0 has ypos=0xD1, xsize=0, tileno=0x42, palno=0x05, xpos=0x120; all other sprites disabled. Fire `line_start`, then a second `line_start`. Required: `spr_count`=1, `overflow`=0, and `rd_idx`=0 returns tileno 0x42, palno 0x05, xpos 0x120, yrow 0.
- Tall sprite: vline=0x10; ypos=0xC1 with xsize=2'b10. Required: match with yrow=0x00. With ypos=0xC0 there is no match (y_v_add=0xDF).
- Overflow: all 64 sprites match. Required: scan ends after 16×3 clocks, then `spr_count`=16, `overflow`=1, and `rd_idx`=15 returns sprite 15.
- Abort: a second `line_start` arrives 30 clocks into a scan that has matched 2 sprites by then. Required: `spr_count`=2, `overflow`=1, and the new scan starts from sprite 0.
- Disable and empty: a matching sprite with disable=1. Required: `spr_count`=0, and `rd_data`=0 for every `rd_idx`.
- Reset mid-scan: assert `reset` at clock 50 of a scan. Required: all outputs take their reset values on the next edge, with no `scan_done` pulse.
